// File: rtl/stream_in_pkg.sv
// Shared widths, lane-state encoding and default depth for the stream-IN packer.
package stream_in_pkg;

  localparam int WORD_W        = 32;
  localparam int BYTE_W        = 8;
  localparam int LANES         = WORD_W / BYTE_W;
  localparam int DEFAULT_DEPTH = 16;

  // Byte lane the next accepted byte will be written into.
  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_e;

endpackage

// File: rtl/stream_in_sync_fifo.sv
// First-word-fall-through FIFO of packed words plus frame-last flag.
// Head entry is read combinationally so a word written at edge t is
// visible on rd_data in cycle t+1.
module stream_in_sync_fifo
  import stream_in_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1,
  parameter int EW    = WORD_W + 1
) (
  input  logic          clk_100,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [EW-1:0] wr_data,
  input  logic          rd_en,
  output logic [EW-1:0] rd_data,
  output logic          avail,
  output logic          full,
  output logic [LW-1:0] level,
  output logic          underrun_err
);

  localparam int AW = $clog2(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          underrun_reg;
  logic          empty;
  logic          do_wr;
  logic          do_rd;

  // Pointers carry one extra wrap bit; equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign avail        = !empty;
  assign level        = level_reg;
  assign underrun_err = underrun_reg;
  // Head is forced to zero while empty so stale storage never leaks out.
  assign rd_data      = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  // Pointer and level bookkeeping; flush behaves like reset for these.
  always_ff @(posedge clk_100) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      if (do_wr && !do_rd)      level_reg <= level_reg + LW'(1);
      else if (!do_wr && do_rd) level_reg <= level_reg - LW'(1);
    end
  end

  // Sticky underrun flag; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk_100) begin
    if (reset) underrun_reg <= 1'b0;
    else if (rd_en && empty) underrun_reg <= 1'b1;
  end

  // Storage write; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk_100) begin
    if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/stream_in_word_packer.sv
// Packs an 8-bit pixel stream into little-endian 32-bit words with a
// frame-last flag and buffers them for the stream-IN writer.
module stream_in_word_packer
  import stream_in_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              stream_in_mode_selected,
  input  logic [BYTE_W-1:0] src_data,
  input  logic              src_valid,
  input  logic              src_last,
  output logic              src_ready,
  input  logic              word_take,
  output logic [WORD_W-1:0] data_for_output,
  output logic              word_last,
  output logic              word_avail,
  output logic [LW-1:0]     level,
  output logic              underrun_err
);

  lane_e             lane_reg;
  lane_e             lane_next;
  logic [WORD_W-1:0] staging_reg;
  logic [WORD_W-1:0] staging_next;
  logic [WORD_W-1:0] merged_word;
  logic              fifo_full;
  logic              accept;
  logic              word_done;
  logic              push;
  logic [WORD_W:0]   push_data;
  logic [WORD_W:0]   head_data;

  assign src_ready = stream_in_mode_selected && !fifo_full;
  assign accept    = src_valid && src_ready;
  assign word_done = accept && ((lane_reg == LANE3) || src_last);

  // Staging with the incoming byte dropped into the current lane; lanes not
  // yet filled stay zero because staging is cleared after every word.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign merged_word[BYTE_W*gi +: BYTE_W] =
        (accept && (lane_reg == lane_e'(2'(gi)))) ? src_data
                                                  : staging_reg[BYTE_W*gi +: BYTE_W];
    end
  endgenerate

  // Lane state register.
  always_ff @(posedge clk_100) begin
    if (reset) lane_reg <= LANE0;
    else       lane_reg <= lane_next;
  end

  // Next lane: advance per accepted byte, return to LANE0 on word close or disable.
  always_comb begin
    lane_next = lane_reg;
    if (!stream_in_mode_selected)
      lane_next = LANE0;
    else if (word_done)
      lane_next = LANE0;
    else if (accept)
      lane_next = lane_e'(lane_reg + 2'd1);
  end

  // Outputs of the lane FSM: staging update and FIFO push of completed words.
  always_comb begin
    staging_next = staging_reg;
    push         = 1'b0;
    push_data    = {src_last, merged_word};
    if (!stream_in_mode_selected) begin
      staging_next = '0;
    end else if (word_done) begin
      staging_next = '0;
      push         = 1'b1;
    end else if (accept) begin
      staging_next = merged_word;
    end
  end

  // Staging register holding the partially assembled word.
  always_ff @(posedge clk_100) begin
    if (reset) staging_reg <= '0;
    else       staging_reg <= staging_next;
  end

  stream_in_sync_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW),
    .EW    (WORD_W + 1)
  ) u_fifo (
    .clk_100      (clk_100),
    .reset        (reset),
    .flush        (!stream_in_mode_selected),
    .wr_en        (push),
    .wr_data      (push_data),
    .rd_en        (word_take),
    .rd_data      (head_data),
    .avail        (word_avail),
    .full         (fifo_full),
    .level        (level),
    .underrun_err (underrun_err)
  );

  assign data_for_output = head_data[WORD_W-1:0];
  assign word_last       = head_data[WORD_W];

endmodule

// File: tb/tb_stream_in_word_packer.sv
// Randomised and directed bench for stream_in_word_packer against a
// queue-based reference model of the packing and buffering rules.
module tb_stream_in_word_packer;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk_100 = 1'b0;
  logic          reset;
  logic          stream_in_mode_selected;
  logic [7:0]    src_data;
  logic          src_valid;
  logic          src_last;
  logic          src_ready;
  logic          word_take;
  logic [31:0]   data_for_output;
  logic          word_last;
  logic          word_avail;
  logic [LW-1:0] level;
  logic          underrun_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: buffered words {last, word}, pending bytes, sticky flag.
  bit [32:0] mq[$];
  bit [7:0]  part[$];
  bit        m_under = 1'b0;

  always #5 clk_100 = ~clk_100;

  stream_in_word_packer #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk_100                 (clk_100),
    .reset                   (reset),
    .stream_in_mode_selected (stream_in_mode_selected),
    .src_data                (src_data),
    .src_valid               (src_valid),
    .src_last                (src_last),
    .src_ready               (src_ready),
    .word_take               (word_take),
    .data_for_output         (data_for_output),
    .word_last               (word_last),
    .word_avail              (word_avail),
    .level                   (level),
    .underrun_err            (underrun_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge of the specified behaviour to the model.
  function automatic void model_edge(bit m, bit v, bit [7:0] d, bit l, bit t, bit r);
    int        sz;
    bit [31:0] w;
    if (r) begin
      mq.delete(); part.delete(); m_under = 1'b0;
      return;
    end
    sz = mq.size();
    if (t && sz == 0) m_under = 1'b1;
    if (!m) begin
      mq.delete(); part.delete();
      return;
    end
    if (t && sz > 0) begin
      $display("tx word %08h last %0d", mq[0][31:0], mq[0][32]);
      void'(mq.pop_front());
    end
    if (v && sz < DEPTH) begin
      part.push_back(d);
      if (part.size() == 4 || l) begin
        w = '0;
        foreach (part[i]) w[8*i +: 8] = part[i];
        mq.push_back({l, w});
        part.delete();
      end
    end
  endfunction

  task automatic check_outputs();
    chk("word_avail", word_avail, mq.size() > 0);
    chk("data", data_for_output, mq.size() > 0 ? mq[0][31:0] : 32'h0);
    chk("word_last", word_last, mq.size() > 0 ? mq[0][32] : 1'b0);
    chk("level", level, mq.size());
    chk("src_ready", src_ready, stream_in_mode_selected && (mq.size() < DEPTH));
    chk("underrun", underrun_err, m_under);
  endtask

  // Drive one cycle from the falling edge, model the rising edge, check at the next falling edge.
  task automatic step(input bit m, input bit v, input bit [7:0] d, input bit l,
                      input bit t, input bit r);
    stream_in_mode_selected = m; src_valid = v; src_data = d;
    src_last = l; word_take = t; reset = r;
    @(posedge clk_100);
    model_edge(m, v, d, l, t, r);
    @(negedge clk_100);
    check_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && word_avail; i++) step(1, 0, 8'h00, 0, 1, 0);
  endtask

  initial begin
    int sent;
    @(negedge clk_100);
    step(0, 0, 8'h00, 0, 0, 1);
    step(1, 0, 8'h00, 0, 0, 1);
    chk("rst_level", level, 0);
    chk("rst_ready", src_ready, 1);

    // Four bytes build one little-endian word.
    step(1, 1, 8'h11, 0, 0, 0);
    step(1, 1, 8'h22, 0, 0, 0);
    step(1, 1, 8'h33, 0, 0, 0);
    step(1, 1, 8'h44, 0, 0, 0);
    chk("w4_data", data_for_output, 32'h44332211);
    chk("w4_last", word_last, 0);
    chk("w4_level", level, 1);
    step(1, 0, 8'h00, 0, 1, 0);

    // Short frame closes early, next byte restarts at lane 0.
    step(1, 1, 8'hAA, 0, 0, 0);
    step(1, 1, 8'hBB, 1, 0, 0);
    chk("short_data", data_for_output, 32'h0000BBAA);
    chk("short_last", word_last, 1);
    step(1, 1, 8'h01, 0, 1, 0);
    step(1, 1, 8'h02, 0, 0, 0);
    step(1, 1, 8'h03, 0, 0, 0);
    step(1, 1, 8'h04, 0, 0, 0);
    chk("lane0_data", data_for_output, 32'h04030201);
    drain();

    // Fill to full with no reads, then free one slot.
    sent = 0;
    for (int c = 0; c < 200 && sent < 64; c++) begin
      bit rdy;
      rdy = (mq.size() < DEPTH);
      step(1, 1, sent[7:0], 0, 0, 0);
      if (rdy) sent++;
    end
    chk("full_sent", sent, 64);
    step(1, 1, 8'hEE, 0, 0, 0);
    chk("full_level", level, 16);
    chk("full_ready", src_ready, 0);
    step(1, 0, 8'h00, 0, 1, 0);
    chk("free_level", level, 15);
    chk("free_ready", src_ready, 1);
    drain();

    // Underrun is sticky until reset.
    step(1, 0, 8'h00, 0, 0, 1);
    step(1, 0, 8'h00, 0, 1, 0);
    chk("under_set", underrun_err, 1);
    chk("under_level", level, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, 0, 0);
    chk("under_sticky", underrun_err, 1);
    step(1, 0, 8'h00, 0, 0, 1);
    chk("under_clear", underrun_err, 0);

    // Streaming with immediate consumption keeps the FIFO shallow.
    for (int i = 0; i < 48; i++) begin
      step(1, 1, 8'(i), 0, word_avail, 0);
      chk("lvl_le2", level <= 2, 1);
    end
    drain();

    // Disable mid-word with three words buffered, then recover cleanly.
    for (int i = 0; i < 12; i++) step(1, 1, 8'(8'h50 + i), 0, 0, 0);
    step(1, 1, 8'h60, 0, 0, 0);
    step(1, 1, 8'h61, 0, 0, 0);
    chk("pre_flush_level", level, 3);
    step(0, 0, 8'h00, 0, 0, 0);
    chk("flush_level", level, 0);
    chk("flush_avail", word_avail, 0);
    step(1, 1, 8'hA0, 0, 0, 0);
    step(1, 1, 8'hA1, 0, 0, 0);
    step(1, 1, 8'hA2, 0, 0, 0);
    step(1, 1, 8'hA3, 0, 0, 0);
    chk("reenable_data", data_for_output, 32'hA3A2A1A0);
    chk("reenable_level", level, 1);

    // Random traffic including disables, reads while empty and resets.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
           8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 99) < 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_in_word_packer.md
STREAM_IN_WORD_PACKER -- requirements
Module: stream_in_word_packer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 32-bit words; SHALL be a power of two, range 4..256.
REQ-002 Parameter LW, default $clog2(DEPTH)+1, width of the level output.
REQ-003 clk_100  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stream_in_mode_selected  in  1  stream-IN enable; low means flush and hold empty.
REQ-006 src_data  in  8  byte from the upstream video/pixel source.
REQ-007 src_valid  in  1  src_data valid.
REQ-008 src_last  in  1  src_data is the last byte of a frame; qualified by src_valid.
REQ-009 src_ready  out  1  packer can accept a byte.
REQ-010 word_take  in  1  downstream consumed the head word this cycle (wired to inverted slave-FIFO write strobe).
REQ-011 data_for_output  out  32  head FIFO word, presented to the stream-IN writer.
REQ-012 word_last  out  1  head word closes a frame.
REQ-013 word_avail  out  1  FIFO non-empty.
REQ-014 level  out  LW  words in the FIFO, 0..DEPTH.
REQ-015 underrun_err  out  1  sticky; word_take seen while empty.

Function
REQ-016 Byte accept SHALL occur on an edge where src_valid && src_ready; src_ready SHALL equal stream_in_mode_selected && (level != DEPTH).
REQ-017 Packer SHALL be a 4-state lane FSM LANE0..LANE3; each accept stores src_data into bits [8*lane+7 : 8*lane] of a staging register (little-endian, first byte at [7:0]) and advances lane; LANE3 wraps to LANE0.
REQ-018 Accept in LANE3, or accept with src_last in any lane, SHALL write the completed word to the FIFO on the same edge, with unfilled upper lanes 0x00, last flag = src_last, and return the FSM to LANE0 with staging cleared.
REQ-019 FIFO read SHALL occur on an edge where word_take && word_avail; read pointer advances, head updates next cycle (first-word-fall-through, zero-latency head).
REQ-020 word_take while level == 0 SHALL leave pointers unchanged and set underrun_err on that edge.
REQ-021 Simultaneous write and read SHALL leave level unchanged; write-only +1, read-only -1.
REQ-022 Because src_ready is low at level == DEPTH, no write SHALL occur when full; a read at full frees a slot visible on src_ready the following cycle.
REQ-023 data_for_output and word_last SHALL be 0 whenever word_avail is 0.
REQ-024 Word written at edge t into an empty FIFO SHALL appear on data_for_output with word_avail = 1 in cycle t+1.
REQ-025 Pointers SHALL be log2(DEPTH)+1 bits wrapping modulo 2*DEPTH; full/empty derived from MSB compare.
REQ-026 stream_in_mode_selected low SHALL, on each edge, reset pointers, level, lane FSM and staging register, discarding partial words; underrun_err is unaffected.

Reset
REQ-027 reset high at an edge SHALL clear pointers, level, lane FSM (LANE0), staging register and underrun_err; outputs then read src_ready = stream_in_mode_selected, word_avail 0, data_for_output 0, word_last 0, level 0.
REQ-028 reset SHALL take priority over all other events in the same cycle, including mid-word and mid-frame; FIFO storage SHALL not require reset.

Structure
REQ-029 Shared package stream_in_pkg SHALL hold WORD_W=32, BYTE_W=8, the lane-state enumeration and the default DEPTH.
REQ-030 FIFO storage, pointers and level SHALL be one sub-module, stream_in_sync_fifo (33-bit entries: word plus last flag); the lane FSM and staging stay in the top.

Verification
REQ-031 Reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> data_for_output = 0x44332211, word_last 0, word_avail 1, level 1 one cycle after the fourth byte.
REQ-032 Bytes 0xAA,0xBB with src_last on 0xBB -> word 0x0000BBAA, word_last 1; next byte 0x01 lands in lane 0.
REQ-033 Push 64 bytes with word_take low (DEPTH=16) -> level 16, src_ready 0; one word_take -> level 15, src_ready 1 next cycle, no byte lost or duplicated.
REQ-034 word_take pulsed with FIFO empty -> underrun_err 1 and stays 1 until reset; level remains 0.
REQ-035 Continuous bytes with word_take asserted every cycle word_avail is 1 -> words emerge in order 0x03020100, 0x07060504, ...; level never exceeds 2.
REQ-036 stream_in_mode_selected dropped after 2 bytes of a word with level 3 -> next cycle level 0, word_avail 0, lane LANE0; re-enable and 4 bytes -> single correct word.
